// File: rtl/conv_pim_pkg.sv
// Shared types and helpers for the streaming PIM convolution block.
//   conv_state_t : controller states
//   clog2_min1   : ceil(log2(n)) clamped to at least 1 (for register widths)
//   sat_add      : signed add saturated to a w-bit two's-complement range
package conv_pim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      REDUCE,
      HOLD
   } conv_state_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Operands are sign-extended to 32 bits by the caller; w must be 1..31.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int unsigned        w);
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi) begin
         return 32'(hi);
      end else if (s < lo) begin
         return 32'(lo);
      end
      return 32'(s);
   endfunction

endpackage

// File: rtl/conv_top.sv
// Behavioural stand-in for the per-channel PIM convolution macro.
// Restarts on reset release, raises done_o after MACRO_LAT cycles and holds it.
// Weight sets: 1 = all-ones kernel, 2 = negated centre tap, others = centre
// tap. Weight set DEPTH-1 with a non-zero first window element models a hung
// macro that never raises done_o.
//   clk, rst  : clock, async active-high reset (held while idle)
//   address_i : weight-set select
//   window_i  : KERNEL_SIZE x KERNEL_SIZE signed window, element e at e*BIT_WIDTH
//   done_o    : result_o is final (sticky until reset)
//   result_o  : signed, saturated to OUT_WIDTH
module conv_top
   import conv_pim_pkg::*;
#(
   parameter int unsigned BIT_WIDTH   = 8,
   parameter int unsigned OUT_WIDTH   = 8,
   parameter int unsigned KERNEL_SIZE = 5,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned ADDR_W      = clog2_min1(DEPTH),
   parameter int unsigned MACRO_LAT   = 4
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [ADDR_W-1:0]                          address_i,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*BIT_WIDTH-1:0] window_i,
   output logic                                       done_o,
   output logic [OUT_WIDTH-1:0]                       result_o
);

   localparam int unsigned KK  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned CTR = KK / 2;
   localparam int unsigned CW  = clog2_min1(MACRO_LAT + 1);

   logic [CW-1:0]        cnt_q;
   logic                 done_q;
   logic [OUT_WIDTH-1:0] result_q;
   logic signed [31:0]   acc_c;
   logic                 stall_c;

   assign stall_c = (address_i == ADDR_W'(DEPTH - 1)) && (window_i[BIT_WIDTH-1:0] != '0);

   // Dot product against the selected fixed kernel.
   always_comb begin
      acc_c = 32'sd0;
      if (address_i == ADDR_W'(1)) begin
         for (int e = 0; e < KK; e++) begin
            acc_c = acc_c + 32'(signed'(window_i[e*BIT_WIDTH +: BIT_WIDTH]));
         end
      end else if (address_i == ADDR_W'(2)) begin
         acc_c = -32'(signed'(window_i[CTR*BIT_WIDTH +: BIT_WIDTH]));
      end else begin
         acc_c = 32'(signed'(window_i[CTR*BIT_WIDTH +: BIT_WIDTH]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         result_q <= OUT_WIDTH'(sat_add(acc_c, 32'sd0, OUT_WIDTH));
         if (!done_q && !stall_c) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(MACRO_LAT - 1)) done_q <= 1'b1;
         end
      end
   end

   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: rtl/pim_sat_add_tree.sv
// Pipelined saturating adder tree reducing N signed W-bit values to one.
// Latency is clog2(N) register stages (combinational pass-through for N=1).
// Each stage adds adjacent pairs; an odd leftover is registered unchanged.
//   clk, rst    : clock, async active-high reset
//   in_valid_i  : launch a reduction of in_data_i
//   in_data_i   : N packed W-bit operands, operand k at [k*W +: W]
//   out_valid_o : sum_o holds the reduced value
//   sum_o       : saturated signed sum
module pim_sat_add_tree
   import conv_pim_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   input  logic [N*W-1:0]   in_data_i,
   output logic             out_valid_o,
   output logic [W-1:0]     sum_o
);

   localparam int unsigned LAT = (N > 1) ? $clog2(N) : 0;

   // Number of live operands after s stages.
   function automatic int unsigned width_at(input int unsigned s);
      return (N + (32'd1 << s) - 32'd1) >> s;
   endfunction

   genvar s, i;
   for (s = 0; s <= LAT; s++) begin : g_stg
      localparam int unsigned NS = width_at(s);
      logic [NS-1:0][W-1:0] data;
      logic                 vld;

      if (s == 0) begin : g_in
         assign data = in_data_i;
         assign vld  = in_valid_i;
      end else begin : g_add
         localparam int unsigned NP = width_at(s - 1);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) vld <= 1'b0;
            else     vld <= g_stg[s-1].vld;
         end

         for (i = 0; i < NS; i++) begin : g_el
            if (2 * i + 1 < NP) begin : g_pair
               always_ff @(posedge clk or posedge rst) begin
                  if (rst) begin
                     data[i] <= '0;
                  end else if (g_stg[s-1].vld) begin
                     data[i] <= W'(sat_add(32'(signed'(g_stg[s-1].data[2*i])),
                                           32'(signed'(g_stg[s-1].data[2*i+1])), W));
                  end
               end
            end else begin : g_pass
               always_ff @(posedge clk or posedge rst) begin
                  if (rst)                    data[i] <= '0;
                  else if (g_stg[s-1].vld)    data[i] <= g_stg[s-1].data[2*i];
               end
            end
         end
      end
   end

   assign out_valid_o = g_stg[LAT].vld;
   assign sum_o       = g_stg[LAT].data[0];

endmodule

// File: rtl/conv_pim_stream.sv
// Streaming multi-channel PIM convolution: assembles a KERNEL_SIZE x
// KERNEL_SIZE window per channel from row beats, runs one conv_top per
// channel, then reduces the channel results with a saturating adder tree.
// Optional macro CONV_PIM_STREAM_RELU_EN clamps negative results to zero.
//   clk, rst       : clock, async active-high reset
//   in_valid/ready : row-beat handshake; input_feature carries one row per channel
//   address        : weight set, taken from the first beat of a window
//   out_valid/ready: result handshake; convValue stable while out_valid
//   timeout_err    : one-cycle pulse when a window is dropped on macro timeout
module conv_pim_stream
   import conv_pim_pkg::*;
#(
   parameter int unsigned BIT_WIDTH     = 8,
   parameter int unsigned OUT_WIDTH     = 8,
   parameter int unsigned KERNEL_SIZE   = 5,
   parameter int unsigned CHANNEL       = 4,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned MACRO_TIMEOUT = 255,
   localparam int unsigned ADDR_W       = clog2_min1(DEPTH)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0] input_feature,
   input  logic [ADDR_W-1:0]                     address,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [OUT_WIDTH-1:0]                  convValue,
   output logic                                  timeout_err
);

   localparam int unsigned ROW_W = KERNEL_SIZE * BIT_WIDTH;
   localparam int unsigned WIN_W = KERNEL_SIZE * ROW_W;
   localparam int unsigned RC_W  = clog2_min1(KERNEL_SIZE);
   localparam int unsigned TC_W  = clog2_min1(MACRO_TIMEOUT + 1);

   conv_state_t                         state_q, state_d;
   logic [RC_W-1:0]                     row_q, row_d;
   logic [ADDR_W-1:0]                   addr_q, addr_d;
   logic [CHANNEL-1:0][WIN_W-1:0]       win_q, win_d;
   logic [CHANNEL-1:0]                  flags_q, flags_d;
   logic [CHANNEL-1:0][OUT_WIDTH-1:0]   res_q, res_d;
   logic [TC_W-1:0]                     tcnt_q, tcnt_d;
   logic                                in_ready_q, in_ready_d;
   logic                                out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]                conv_q, conv_d;
   logic                                tmo_q, tmo_d;

   logic                                accept_c, wr_c, mac_rst_c, all_done_c, tree_go_c;
   logic [CHANNEL-1:0]                  mac_done;
   logic [CHANNEL-1:0][OUT_WIDTH-1:0]   mac_res;
   logic [CHANNEL-1:0][OUT_WIDTH-1:0]   tree_in_c;
   logic                                tree_vld_c;
   logic [OUT_WIDTH-1:0]                tree_sum_c, final_c;

   assign accept_c   = in_valid & in_ready_q;
   // Macros are held in reset outside COMPUTE so each window starts them fresh.
   assign mac_rst_c  = rst | (state_q != COMPUTE);
   assign all_done_c = &(flags_q | mac_done);
   assign tree_go_c  = (state_q == COMPUTE) && all_done_c;

   genvar c;
   for (c = 0; c < CHANNEL; c++) begin : g_ch
      conv_top #(
         .BIT_WIDTH   (BIT_WIDTH),
         .OUT_WIDTH   (OUT_WIDTH),
         .KERNEL_SIZE (KERNEL_SIZE),
         .DEPTH       (DEPTH),
         .ADDR_W      (ADDR_W)
      ) u_mac (
         .clk       (clk),
         .rst       (mac_rst_c),
         .address_i (addr_q),
         .window_i  (win_q[c]),
         .done_o    (mac_done[c]),
         .result_o  (mac_res[c])
      );
   end

   // Channels that finished earlier feed their captured result; the last one feeds live.
   always_comb begin
      for (int k = 0; k < CHANNEL; k++) begin
         tree_in_c[k] = flags_q[k] ? res_q[k] : mac_res[k];
      end
   end

   pim_sat_add_tree #(
      .N (CHANNEL),
      .W (OUT_WIDTH)
   ) u_tree (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (tree_go_c),
      .in_data_i   (tree_in_c),
      .out_valid_o (tree_vld_c),
      .sum_o       (tree_sum_c)
   );

`ifdef CONV_PIM_STREAM_RELU_EN
   assign final_c = tree_sum_c[OUT_WIDTH-1] ? '0 : tree_sum_c;
`else
   assign final_c = tree_sum_c;
`endif

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      addr_d      = addr_q;
      win_d       = win_q;
      flags_d     = '0;
      res_d       = res_q;
      tcnt_d      = '0;
      out_valid_d = out_valid_q;
      conv_d      = conv_q;
      tmo_d       = 1'b0;
      wr_c        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               addr_d = address;
               wr_c   = 1'b1;
               if (KERNEL_SIZE == 1) begin
                  state_d = COMPUTE;
               end else begin
                  state_d = LOAD;
                  row_d   = RC_W'(1);
               end
            end
         end
         LOAD: begin
            if (accept_c) begin
               wr_c = 1'b1;
               if (row_q == RC_W'(KERNEL_SIZE - 1)) begin
                  state_d = COMPUTE;
                  row_d   = '0;
               end else begin
                  row_d = row_q + RC_W'(1);
               end
            end
         end
         COMPUTE: begin
            flags_d = flags_q | mac_done;
            tcnt_d  = tcnt_q + TC_W'(1);
            for (int k = 0; k < CHANNEL; k++) begin
               if (mac_done[k] && !flags_q[k]) res_d[k] = mac_res[k];
            end
            // A zero-latency tree is already valid here; completion beats timeout.
            if (tree_vld_c) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               conv_d      = final_c;
            end else if (all_done_c) begin
               state_d = REDUCE;
            end else if (tcnt_q == TC_W'(MACRO_TIMEOUT - 1)) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end
         end
         REDUCE: begin
            if (tree_vld_c) begin
               state_d     = HOLD;
               out_valid_d = 1'b1;
               conv_d      = final_c;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_c) begin
         for (int k = 0; k < CHANNEL; k++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
               if (row_q == RC_W'(r)) win_d[k][r*ROW_W +: ROW_W] = input_feature[k*ROW_W +: ROW_W];
            end
         end
      end

      in_ready_d = (state_d == IDLE) || (state_d == LOAD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         addr_q      <= '0;
         win_q       <= '0;
         flags_q     <= '0;
         res_q       <= '0;
         tcnt_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         conv_q      <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         addr_q      <= addr_d;
         win_q       <= win_d;
         flags_q     <= flags_d;
         res_q       <= res_d;
         tcnt_q      <= tcnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         conv_q      <= conv_d;
         tmo_q       <= tmo_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign convValue   = conv_q;
   assign timeout_err = tmo_q;

endmodule
